// File: rtl/ball_physics.sv
// ball_physics: owns the Pong ball position, direction and speed.
// Runs an IDLE/SERVE/PLAY state machine, bounces the ball off the top and
// bottom walls and both paddles, detects misses and emits score/hit pulses.
// Ball speed ramps by one step every HITS_PER_STEP paddle returns.
// All motion advances only on timing_tick.
//
// Ports:
//   clk           system clock
//   rst           synchronous active-high reset
//   timing_tick   one-cycle frame strobe
//   still_graphic menu/pause screen active; ball parked at centre
//   y_pad_left    left paddle top y
//   y_pad_right   right paddle top y
//   x_ball        ball left x
//   y_ball        ball top y
//   point_left    one-cycle pulse: left player scored
//   point_right   one-cycle pulse: right player scored
//   hit           one-cycle pulse: ball returned by either paddle
//   serving       high while in SERVE
//   speed         current velocity magnitude (pixels per tick per axis)
module ball_physics #(
    parameter int HOR_PIXELS    = 1024,
    parameter int VER_PIXELS    = 768,
    parameter int BALL_SIZE     = 15,
    parameter int PAD_HEIGHT    = 145,
    parameter int PAD_WIDTH     = 15,
    parameter int X_PAD_L       = 30,
    parameter int X_PAD_R       = 979,
    parameter int V_INIT        = 2,
    parameter int V_MAX         = 6,
    parameter int HITS_PER_STEP = 4,
    parameter int SERVE_DELAY   = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        timing_tick,
    input  logic        still_graphic,
    input  logic [9:0]  y_pad_left,
    input  logic [9:0]  y_pad_right,
    output logic [10:0] x_ball,
    output logic [9:0]  y_ball,
    output logic        point_left,
    output logic        point_right,
    output logic        hit,
    output logic        serving,
    output logic [2:0]  speed
);

    localparam int CNT_W = $clog2(SERVE_DELAY + 1) + 1;
    localparam int HIT_W = $clog2(HITS_PER_STEP + 1) + 1;

    // 12-bit geometry constants; all position math stays in 12 bits so
    // sums such as y + BALL_SIZE + v cannot wrap.
    localparam logic [11:0] XC_C     = 12'((HOR_PIXELS - BALL_SIZE) / 2);
    localparam logic [11:0] YC_C     = 12'((VER_PIXELS - BALL_SIZE) / 2);
    localparam logic [11:0] HOR_C    = 12'(HOR_PIXELS);
    localparam logic [11:0] VER_C    = 12'(VER_PIXELS);
    localparam logic [11:0] BS_C     = 12'(BALL_SIZE);
    localparam logic [11:0] PH_C     = 12'(PAD_HEIGHT);
    localparam logic [11:0] PW_C     = 12'(PAD_WIDTH);
    localparam logic [11:0] XPL_C    = 12'(X_PAD_L);
    localparam logic [11:0] XPR_C    = 12'(X_PAD_R);
    localparam logic [2:0]  VINIT_C  = 3'(V_INIT);
    localparam logic [2:0]  VMAX_C   = 3'(V_MAX);
    localparam logic [CNT_W-1:0] SD_C     = CNT_W'(SERVE_DELAY);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [HIT_W-1:0] HPS_C    = HIT_W'(HITS_PER_STEP);
    localparam logic [HIT_W-1:0] HIT_ZERO = HIT_W'(0);
    localparam logic [HIT_W-1:0] HIT_ONE  = HIT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        PLAY  = 2'd2
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [HIT_W-1:0] hit_cnt_r;
    logic             dir_right_r;
    logic             dir_down_r;

    logic [11:0]      v_s;
    logic [11:0]      x_s;
    logic [11:0]      y_s;
    logic [10:0]      x_next_s;
    logic [9:0]       y_next_s;
    logic             dir_right_next_s;
    logic             dir_down_next_s;
    logic             hit_s;
    logic             score_left_s;
    logic             score_right_s;
    logic [HIT_W-1:0] hit_cnt_next_s;
    logic [2:0]       speed_next_s;

    // Ball's vertical extent touches the paddle's vertical extent.
    function automatic logic pad_overlap(input logic [11:0] y, input logic [11:0] p);
        return ((y + BS_C) >= p) && (y <= (p + PH_C));
    endfunction

    // Widen position and speed into the 12-bit arithmetic domain.
    always_comb begin
        v_s = {9'd0, speed};
        x_s = {1'b0, x_ball};
        y_s = {2'b00, y_ball};
    end

    // Vertical motion with top/bottom wall bounce.
    always_comb begin
        y_next_s        = y_ball;
        dir_down_next_s = dir_down_r;
        if (!dir_down_r) begin
            if (y_s <= v_s) begin
                y_next_s        = 10'd0;
                dir_down_next_s = 1'b1;
            end else begin
                y_next_s = 10'(y_s - v_s);
            end
        end else begin
            if ((y_s + BS_C + v_s) >= VER_C) begin
                y_next_s        = 10'(VER_C - BS_C);
                dir_down_next_s = 1'b0;
            end else begin
                y_next_s = 10'(y_s + v_s);
            end
        end
    end

    // Horizontal motion: paddle hit beats miss, miss beats plain travel.
    always_comb begin
        x_next_s         = x_ball;
        dir_right_next_s = dir_right_r;
        hit_s            = 1'b0;
        score_left_s     = 1'b0;
        score_right_s    = 1'b0;
        if (!dir_right_r) begin
            // x - v <= pad edge is rewritten as x <= pad edge + v to avoid underflow
            if ((x_s >= XPL_C) && (x_s <= (XPL_C + PW_C + v_s)) &&
                pad_overlap(y_s, {2'b00, y_pad_left})) begin
                x_next_s         = 11'(XPL_C + PW_C);
                dir_right_next_s = 1'b1;
                hit_s            = 1'b1;
            end else if (x_s <= v_s) begin
                score_right_s = 1'b1;
            end else begin
                x_next_s = 11'(x_s - v_s);
            end
        end else begin
            if (((x_s + BS_C) <= (XPR_C + PW_C)) && ((x_s + BS_C + v_s) >= XPR_C) &&
                pad_overlap(y_s, {2'b00, y_pad_right})) begin
                x_next_s         = 11'(XPR_C - BS_C);
                dir_right_next_s = 1'b0;
                hit_s            = 1'b1;
            end else if ((x_s + BS_C + v_s) >= HOR_C) begin
                score_left_s = 1'b1;
            end else begin
                x_next_s = 11'(x_s + v_s);
            end
        end
    end

    // Rally speed ramp: every HITS_PER_STEP returns add one, capped at V_MAX.
    always_comb begin
        hit_cnt_next_s = hit_cnt_r;
        speed_next_s   = speed;
        if (hit_s) begin
            if ((hit_cnt_r + HIT_ONE) == HPS_C) begin
                hit_cnt_next_s = HIT_ZERO;
                if (speed < VMAX_C) begin
                    speed_next_s = speed + 3'd1;
                end else begin
                    speed_next_s = VMAX_C;
                end
            end else begin
                hit_cnt_next_s = hit_cnt_r + HIT_ONE;
            end
        end else begin
            hit_cnt_next_s = hit_cnt_r;
        end
    end

    // Serve/play state machine and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= SERVE;
            cnt_r       <= SD_C;
            x_ball      <= 11'(XC_C);
            y_ball      <= 10'(YC_C);
            dir_right_r <= 1'b0;
            dir_down_r  <= 1'b0;
            speed       <= VINIT_C;
            hit_cnt_r   <= HIT_ZERO;
            point_left  <= 1'b0;
            point_right <= 1'b0;
            hit         <= 1'b0;
            serving     <= 1'b1;
        end else if (still_graphic) begin
            state_r     <= IDLE;
            cnt_r       <= SD_C;
            x_ball      <= 11'(XC_C);
            y_ball      <= 10'(YC_C);
            dir_right_r <= 1'b0;
            dir_down_r  <= 1'b0;
            speed       <= VINIT_C;
            hit_cnt_r   <= HIT_ZERO;
            point_left  <= 1'b0;
            point_right <= 1'b0;
            hit         <= 1'b0;
            serving     <= 1'b0;
        end else begin
            point_left  <= 1'b0;
            point_right <= 1'b0;
            hit         <= 1'b0;
            case (state_r)
                IDLE: begin
                    state_r <= SERVE;
                    cnt_r   <= SD_C;
                    serving <= 1'b1;
                end
                SERVE: begin
                    if (timing_tick) begin
                        if (cnt_r == CNT_ZERO) begin
                            state_r <= PLAY;
                            serving <= 1'b0;
                        end else begin
                            cnt_r <= cnt_r - CNT_ONE;
                        end
                    end
                end
                PLAY: begin
                    if (timing_tick) begin
                        if (score_left_s || score_right_s) begin
                            // re-serve toward the player who just conceded
                            state_r     <= SERVE;
                            cnt_r       <= SD_C;
                            serving     <= 1'b1;
                            x_ball      <= 11'(XC_C);
                            y_ball      <= 10'(YC_C);
                            dir_right_r <= score_left_s;
                            dir_down_r  <= 1'b0;
                            speed       <= VINIT_C;
                            hit_cnt_r   <= HIT_ZERO;
                            point_left  <= score_left_s;
                            point_right <= score_right_s;
                        end else begin
                            x_ball      <= x_next_s;
                            y_ball      <= y_next_s;
                            dir_right_r <= dir_right_next_s;
                            dir_down_r  <= dir_down_next_s;
                            hit         <= hit_s;
                            hit_cnt_r   <= hit_cnt_next_s;
                            speed       <= speed_next_s;
                        end
                    end
                end
                default: begin
                    state_r <= SERVE;
                    cnt_r   <= SD_C;
                    serving <= 1'b1;
                    x_ball  <= 11'(XC_C);
                    y_ball  <= 10'(YC_C);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ball_physics.sv
// Testbench for ball_physics: directed scenarios followed by randomized
// paddle/tick/pause stimulus, every cycle checked against a plain-integer
// model of the game rules.
module tb_ball_physics;

    localparam int HOR = 1024, VER = 768, BS = 15, PH = 145, PW = 15;
    localparam int XPL = 30, XPR = 979, VI = 2, VM = 3, HPS = 4, SD = 3;
    localparam int XC = (HOR - BS) / 2;
    localparam int YC = (VER - BS) / 2;
    localparam int M_IDLE = 0, M_SERVE = 1, M_PLAY = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic        sg = 1'b0;
    logic [9:0]  ypl = 10'd300;
    logic [9:0]  ypr = 10'd300;
    logic [10:0] x_ball;
    logic [9:0]  y_ball;
    logic        point_left, point_right, hit, serving;
    logic [2:0]  speed;

    int n_assert = 0;
    int n_fail = 0;

    // model state
    int m_mode, m_cnt, m_x, m_y, m_right, m_down, m_spd, m_hits;
    int m_pl, m_pr, m_hit;

    int tper = 4;
    int tphase = 0;
    int rand_tick = 0;
    int pad_mode = 0;   // 0 hold, 1 track ball, 2 avoid ball

    ball_physics #(
        .HOR_PIXELS(HOR), .VER_PIXELS(VER), .BALL_SIZE(BS), .PAD_HEIGHT(PH),
        .PAD_WIDTH(PW), .X_PAD_L(XPL), .X_PAD_R(XPR), .V_INIT(VI), .V_MAX(VM),
        .HITS_PER_STEP(HPS), .SERVE_DELAY(SD)
    ) dut (
        .clk(clk), .rst(rst), .timing_tick(tick), .still_graphic(sg),
        .y_pad_left(ypl), .y_pad_right(ypr),
        .x_ball(x_ball), .y_ball(y_ball), .point_left(point_left),
        .point_right(point_right), .hit(hit), .serving(serving), .speed(speed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int overlaps(input int y, input int p);
        return ((y + BS >= p) && (y <= p + PH)) ? 1 : 0;
    endfunction

    function automatic void model_centre();
        m_x = XC; m_y = YC; m_spd = VI; m_hits = 0; m_down = 0;
    endfunction

    // One clock of the game rules, using the inputs sampled at this edge.
    function automatic void model_step();
        int v, nx, ny, nr, nd, got_hit, sc_l, sc_r;
        if (rst) begin
            m_mode = M_SERVE; m_cnt = SD; model_centre(); m_right = 0;
            m_pl = 0; m_pr = 0; m_hit = 0;
        end else if (sg) begin
            m_mode = M_IDLE; model_centre(); m_right = 0;
            m_pl = 0; m_pr = 0; m_hit = 0;
        end else begin
            m_pl = 0; m_pr = 0; m_hit = 0;
            if (m_mode == M_IDLE) begin
                m_mode = M_SERVE; m_cnt = SD;
            end else if (tick && m_mode == M_SERVE) begin
                if (m_cnt == 0) m_mode = M_PLAY;
                else m_cnt = m_cnt - 1;
            end else if (tick && m_mode == M_PLAY) begin
                v = m_spd; nd = m_down; nr = m_right;
                got_hit = 0; sc_l = 0; sc_r = 0; nx = m_x;
                if (m_down == 0) begin
                    if (m_y <= v) begin ny = 0; nd = 1; end
                    else ny = m_y - v;
                end else begin
                    if (m_y + BS + v >= VER) begin ny = VER - BS; nd = 0; end
                    else ny = m_y + v;
                end
                if (m_right == 0) begin
                    if (m_x >= XPL && m_x - v <= XPL + PW && overlaps(m_y, int'(ypl)) == 1) begin
                        nx = XPL + PW; nr = 1; got_hit = 1;
                    end else if (m_x <= v) sc_r = 1;
                    else nx = m_x - v;
                end else begin
                    if (m_x + BS <= XPR + PW && m_x + BS + v >= XPR && overlaps(m_y, int'(ypr)) == 1) begin
                        nx = XPR - BS; nr = 0; got_hit = 1;
                    end else if (m_x + BS + v >= HOR) sc_l = 1;
                    else nx = m_x + v;
                end
                if (sc_l == 1 || sc_r == 1) begin
                    m_mode = M_SERVE; m_cnt = SD; model_centre();
                    m_right = sc_l; m_pl = sc_l; m_pr = sc_r;
                end else begin
                    m_x = nx; m_y = ny; m_right = nr; m_down = nd; m_hit = got_hit;
                    if (got_hit == 1) begin
                        m_hits++;
                        if (m_hits == HPS) begin
                            m_hits = 0;
                            m_spd = (m_spd + 1 > VM) ? VM : m_spd + 1;
                        end
                    end
                end
            end
        end
    endfunction

    task automatic check_outputs();
        chk("x_ball", 32'(x_ball), m_x);
        chk("y_ball", 32'(y_ball), m_y);
        chk("serving", 32'(serving), (m_mode == M_SERVE) ? 1 : 0);
        chk("speed", 32'(speed), m_spd);
        chk("point_left", 32'(point_left), m_pl);
        chk("point_right", 32'(point_right), m_pr);
        chk("hit", 32'(hit), m_hit);
    endtask

    task automatic drive_pads();
        int p;
        if (pad_mode == 1) begin
            p = m_y - 50;
            if (p < 0) p = 0;
            if (p > VER - PH) p = VER - PH;
            ypl = 10'(p); ypr = 10'(p);
        end else if (pad_mode == 2) begin
            p = (m_y < 384) ? (VER - PH) : 0;
            ypl = 10'(p); ypr = 10'(p);
        end
    endtask

    // One clock: drive inputs, let the edge happen, update model, compare.
    task automatic step();
        if (rand_tick != 0) tick = ($urandom_range(0, 1) == 0);
        else begin
            tick = (tphase == 0);
            tphase = (tphase + 1) % tper;
        end
        drive_pads();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic next_tick();
        int done = 0;
        for (int i = 0; i < 64 && done == 0; i++) begin
            step();
            if (tick) done = 1;
        end
        chk("tick_timeout", done, 1);
    endtask

    initial begin
        int found;
        int hits_seen;

        // 1: reset and serve delay
        rst = 1'b1; sg = 1'b0; tper = 4;
        step(); step();
        chk("rst_x", 32'(x_ball), 504);
        chk("rst_y", 32'(y_ball), 376);
        chk("rst_serving", 32'(serving), 1);
        chk("rst_speed", 32'(speed), 2);
        rst = 1'b0;
        for (int k = 1; k <= SD; k++) begin
            next_tick();
            chk("serve_hold", 32'(serving), 1);
            chk("serve_x", 32'(x_ball), 504);
        end
        next_tick();
        chk("serve_exit", 32'(serving), 0);
        chk("serve_exit_x", 32'(x_ball), 504);
        next_tick();
        chk("first_move_x", 32'(x_ball), 502);
        chk("first_move_y", 32'(y_ball), 374);

        // 2: top wall bounce
        tper = 2; pad_mode = 1;
        found = 0;
        for (int i = 0; i < 20000 && found == 0; i++) begin
            step();
            if (m_y == 0) found = 1;
        end
        chk("wait_top_wall", found, 1);
        chk("top_wall_y", 32'(y_ball), 0);
        next_tick();
        chk("top_wall_after", 32'(y_ball), 2);

        // 3: first left paddle return, then 5: speed ramp
        hits_seen = 0;
        found = 0;
        for (int i = 0; i < 30000 && hits_seen < 8; i++) begin
            step();
            if (m_hit == 1) begin
                hits_seen++;
                chk("hit_pulse", 32'(hit), 1);
                if (hits_seen == 1) begin
                    chk("left_hit_x", 32'(x_ball), 45);
                    next_tick();
                    chk("left_hit_next_x", 32'(x_ball), 47);
                    chk("hit_pulse_clear", 32'(hit), 0);
                end
                if (hits_seen == 3) chk("speed_hit3", 32'(speed), 2);
                if (hits_seen == 4) chk("speed_hit4", 32'(speed), 3);
                if (hits_seen == 8) chk("speed_hit8", 32'(speed), 3);
            end
        end
        chk("wait_8_hits", hits_seen, 8);

        // 4: miss on the left
        pad_mode = 2;
        found = 0;
        for (int i = 0; i < 20000 && found == 0; i++) begin
            step();
            if (m_pr == 1 || m_pl == 1) found = 1;
        end
        chk("wait_miss", found, 1);
        chk("miss_point_right", 32'(point_right), 1);
        chk("miss_x", 32'(x_ball), 504);
        chk("miss_y", 32'(y_ball), 376);
        chk("miss_serving", 32'(serving), 1);
        chk("miss_speed", 32'(speed), 2);
        step();
        chk("miss_pulse_clear", 32'(point_right), 0);
        for (int k = 0; k < SD + 2; k++) next_tick();
        chk("reserve_left_x", 32'(x_ball), 502);

        // 6: pause mid-play
        pad_mode = 1;
        found = 0;
        for (int i = 0; i < 20000 && found == 0; i++) begin
            step();
            if (m_mode == M_PLAY && m_x >= 700) found = 1;
        end
        chk("wait_x700", found, 1);
        sg = 1'b1;
        step();
        chk("pause_x", 32'(x_ball), 504);
        chk("pause_y", 32'(y_ball), 376);
        chk("pause_no_pl", 32'(point_left), 0);
        chk("pause_no_pr", 32'(point_right), 0);
        chk("pause_serving", 32'(serving), 0);
        sg = 1'b0;
        step();
        chk("unpause_serving", 32'(serving), 1);
        for (int k = 0; k < SD + 1; k++) begin
            next_tick();
            chk("unpause_hold_x", 32'(x_ball), 504);
        end
        next_tick();
        chk("unpause_move_x", 32'(x_ball), 502);

        // randomized phase
        rand_tick = 1;
        for (int i = 0; i < 6000; i++) begin
            if (i % 300 == 0) begin
                pad_mode = $urandom_range(0, 2);
                if (pad_mode == 0) begin
                    ypl = 10'($urandom_range(0, VER - PH));
                    ypr = 10'($urandom_range(0, VER - PH));
                end
            end
            sg  = ($urandom_range(0, 799) == 0);
            rst = ($urandom_range(0, 1999) == 0);
            step();
        end
        sg = 1'b0; rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
